// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID-stage decode with condition check, ID/EX control register, memory handshake sequencer
module pipelined_control_unit #(
  parameter int CMD_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       mode,
  input  logic [3:0]       opcode,
  input  logic             s_bit,
  input  logic             i_bit,
  input  logic [3:0]       cond,
  input  logic [3:0]       status,
  input  logic             freeze,
  input  logic             flush,
  input  logic             mem_rdy,
  output logic             ex_valid,
  output logic             ex_wb_en,
  output logic             ex_mem_r_en,
  output logic             ex_mem_w_en,
  output logic             ex_b,
  output logic             ex_s,
  output logic             ex_imm,
  output logic [CMD_W-1:0] ex_exe_cmd,
  output logic             ex_illegal,
  output logic             mem_req,
  output logic             stall,
  output logic             mem_timeout
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_n;
  logic [TO_W-1:0] cnt, cnt_n;
  logic to_n;
  logic [3:0] d_cmd;
  logic d_wb, d_r, d_w, d_b, d_s, d_imm, d_ill;
  logic n, z, c, v, base, cond_ok, live, pass, mem_op, at_to;
  logic [CMD_W+7:0] ex_q, ex_d;
  assign {n, z, c, v} = status;
  // Raw field decode; illegal encodings only raise d_ill and are masked below
  always_comb begin
    d_cmd = 4'd0;
    d_wb  = 1'b0;
    d_r   = 1'b0;
    d_w   = 1'b0;
    d_b   = 1'b0;
    d_s   = 1'b0;
    d_imm = 1'b0;
    d_ill = 1'b0;
    case (mode)
      2'd0: begin
        d_imm = i_bit;
        d_wb  = 1'b1;
        d_s   = s_bit;
        case (opcode)
          4'd13:   d_cmd = 4'd1;
          4'd15:   d_cmd = 4'd9;
          4'd4:    d_cmd = 4'd2;
          4'd5:    d_cmd = 4'd3;
          4'd2:    d_cmd = 4'd4;
          4'd6:    d_cmd = 4'd5;
          4'd0:    d_cmd = 4'd6;
          4'd12:   d_cmd = 4'd7;
          4'd1:    d_cmd = 4'd8;
          4'd10:   begin d_cmd = 4'd4; d_wb = 1'b0; d_s = 1'b1; end
          4'd8:    begin d_cmd = 4'd6; d_wb = 1'b0; d_s = 1'b1; end
          default: d_ill = 1'b1;
        endcase
      end
      2'd1: begin
        d_ill = opcode != 4'd4;
        d_cmd = 4'd2;
        d_r   = s_bit;
        d_wb  = s_bit;
        d_w   = !s_bit;
        d_s   = s_bit;
      end
      2'd2: begin
        d_b   = 1'b1;
        d_imm = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end
  // Odd condition codes are the complement of the preceding even code
  always_comb begin
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & !z;
      3'd5:    base = n == v;
      3'd6:    base = !z & (n == v);
      default: base = 1'b1;
    endcase
    cond_ok = base ^ cond[0];
  end
  assign live = id_valid & !d_ill;
  assign pass = live & cond_ok;
  assign ex_d = {id_valid, id_valid & d_ill, pass & d_wb, pass & d_r, pass & d_w, pass & d_b, pass & d_s,
                 live & d_imm, live ? CMD_W'(d_cmd) : {CMD_W{1'b0}}};
  assign {ex_valid, ex_illegal, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm, ex_exe_cmd} = ex_q;
  assign mem_op  = ex_valid & (ex_mem_r_en | ex_mem_w_en);
  assign at_to   = state == S_WAIT && cnt == TO_W'(MEM_TIMEOUT);
  assign stall   = mem_op & !mem_rdy & !at_to;
  assign mem_req = state == S_WAIT || mem_op;
  // ID/EX register: a pending memory op outranks freeze, which outranks flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else if (!stall && !freeze) ex_q <= flush ? '0 : ex_d;
  end
  // Handshake sequencer state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mem_timeout <= to_n;
    end
  end
  // Enter WAIT on an unacknowledged op; leave on ack or when the wait budget runs out
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    to_n    = mem_timeout;
    if (state == S_IDLE) begin
      if (mem_op && !mem_rdy) begin
        state_n = S_WAIT;
        cnt_n   = TO_W'(1);
      end
    end else if (mem_rdy || at_to) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      to_n    = mem_timeout | !mem_rdy;
    end else cnt_n = cnt + TO_W'(1);
  end
endmodule
